// File: rtl/pry2oht_rr_if.sv
// Grant handshake bundle between the round-robin arbiter and the shared resource.
// The arbiter is the master: it drives the grant and its valid, and samples the
// request vector, the lock and the consumer's ready.
interface pry2oht_rr_if #(
    parameter int WIDTH = 8
) ();
    localparam int WIDTH_LOG = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]     req;
    logic                 lck;
    logic [WIDTH-1:0]     gnt;
    logic [WIDTH_LOG-1:0] idx;
    logic                 vld;
    logic                 rdy;

    modport master (
        input  req,
        input  lck,
        input  rdy,
        output gnt,
        output idx,
        output vld
    );

    modport slave (
        output req,
        output lck,
        output rdy,
        input  gnt,
        input  idx,
        input  vld
    );
endinterface

// File: rtl/pry2oht_rr.sv
// Round-robin arbiter: registered one-hot grant offered over valid/ready, with a
// rotating priority mask for fairness and a lock that re-offers the same grant
// across multi-beat transfers.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no grant offered; waits for any request
// ST_OFFER | gnt/idx valid (vld=1); held until the consumer takes it
module pry2oht_rr #(
    parameter int WIDTH          = 8,
    parameter     DIRECTION      = "LSB",
    parameter int IMPLEMENTATION = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    pry2oht_rr_if.master arb
);
    localparam int WIDTH_LOG = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam bit DIR_MSB   = (DIRECTION == "MSB");

    // A single requester has nothing to rotate, so its mask stays empty.
    localparam logic [WIDTH-1:0] PTR_RST = (WIDTH == 1) ? '0 : '1;

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "pry2oht_rr: WIDTH must be at least 1");
    end
    if ((DIRECTION != "LSB") && (DIRECTION != "MSB")) begin : g_bad_dir
        $fatal(1, "pry2oht_rr: DIRECTION must be \"LSB\" or \"MSB\"");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_gnt;
    logic [WIDTH-1:0]     w_gnt_nxt;
    logic [WIDTH_LOG-1:0] r_idx;
    logic [WIDTH_LOG-1:0] w_idx_nxt;
    logic [WIDTH-1:0]     r_ptr;
    logic [WIDTH-1:0]     w_ptr_nxt;

    logic [WIDTH-1:0]     w_ptr_adv;
    logic [WIDTH-1:0]     w_ptr_use;
    logic [WIDTH-1:0]     w_masked;
    logic [WIDTH-1:0]     w_cand;
    logic [WIDTH-1:0]     w_scan;
    logic [WIDTH-1:0]     w_pick;
    logic [WIDTH-1:0]     w_sel;
    logic [WIDTH_LOG-1:0] w_sel_idx;

    // Bit reversal lets one lowest-bit-first core serve both scan directions.
    function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Loop core: walk upward and keep the first set bit.
    function automatic logic [WIDTH-1:0] f_lsb_loop(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Vector core: log-depth prefix OR, then keep bits with nothing set below.
    function automatic logic [WIDTH-1:0] f_lsb_vec(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        m = v;
        for (int s = 1; s < WIDTH; s = s * 2) begin
            m = m | (m << s);
        end
        return v & ~(m << 1);
    endfunction

    // Adder core: two's-complement isolates the lowest set bit.
    function automatic logic [WIDTH-1:0] f_lsb_add(input logic [WIDTH-1:0] v);
        return v & (~v + WIDTH'(1));
    endfunction

    function automatic logic [WIDTH_LOG-1:0] f_enc(input logic [WIDTH-1:0] v);
        logic [WIDTH_LOG-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                r = r | WIDTH_LOG'(i);
            end
        end
        return r;
    endfunction

    // Mask of requesters that rank ahead once the current grant has been taken.
    always_comb begin
        if (DIR_MSB) begin
            w_ptr_adv = r_gnt - WIDTH'(1);
        end else begin
            w_ptr_adv = ~((r_gnt << 1) - WIDTH'(1));
        end
    end

    // In OFFER the next grant must already respect the advanced pointer, so the
    // selection sees it combinationally rather than waiting a cycle.
    always_comb begin
        w_ptr_use = (r_state == ST_OFFER) ? w_ptr_adv : r_ptr;
        w_masked  = arb.req & w_ptr_use;
        w_cand    = (|w_masked) ? w_masked : arb.req;
        w_scan    = DIR_MSB ? f_rev(w_cand) : w_cand;
    end

    if (IMPLEMENTATION == 0) begin : g_core_loop
        assign w_pick = f_lsb_loop(w_scan);
    end else if (IMPLEMENTATION == 1) begin : g_core_vec
        assign w_pick = f_lsb_vec(w_scan);
    end else if (IMPLEMENTATION == 2) begin : g_core_add
        assign w_pick = f_lsb_add(w_scan);
    end else begin : g_bad_impl
        $fatal(1, "pry2oht_rr: IMPLEMENTATION must be 0, 1 or 2");
        assign w_pick = '0;
    end

    // Map the core's result back to client numbering and encode it.
    always_comb begin
        w_sel     = DIR_MSB ? f_rev(w_pick) : w_pick;
        w_sel_idx = f_enc(w_sel);
    end

    // Next-state and next-grant decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (|arb.req) begin
                    w_gnt_nxt   = w_sel;
                    w_idx_nxt   = w_sel_idx;
                    w_state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // A locked beat re-offers the same grant and leaves the pointer.
                if (arb.rdy && !arb.lck) begin
                    w_ptr_nxt = w_ptr_adv;
                    if (|w_sel) begin
                        w_gnt_nxt = w_sel;
                        w_idx_nxt = w_sel_idx;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant and pointer registers; reset drops any pending grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= PTR_RST;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign arb.gnt = r_gnt;
    assign arb.idx = r_idx;
    assign arb.vld = (r_state == ST_OFFER);

endmodule

// File: tb/tb_pry2oht_rr.sv
// Bench for pry2oht_rr: six WIDTH=4 instances (LSB/MSB x three selection cores)
// share one stimulus stream and are checked every cycle against a circular-scan
// round-robin model, with directed scenarios pinning literal grant sequences.
module tb_pry2oht_rr;
    localparam int W    = 4;
    localparam int NDUT = 6;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       lck;
    logic       rdy;

    logic [3:0] gnt_a [NDUT];
    logic [1:0] idx_a [NDUT];
    logic       vld_a [NDUT];

    int tests;
    int failed;
    bit chk_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pry2oht_rr_if #(.WIDTH(W)) u_if ();
        assign u_if.req = req;
        assign u_if.lck = lck;
        assign u_if.rdy = rdy;
        pry2oht_rr #(
            .WIDTH(W),
            .DIRECTION((g / 3) == 1 ? "MSB" : "LSB"),
            .IMPLEMENTATION(g % 3)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .arb  (u_if)
        );
        assign gnt_a[g] = u_if.gnt;
        assign idx_a[g] = u_if.idx;
        assign vld_a[g] = u_if.vld;
    end

    // Model, per direction d (0 = LSB, 1 = MSB): round-robin is a circular scan
    // starting just after (LSB) or just before (MSB) the last client served.
    bit m_vld  [2];
    int m_cur  [2];
    int m_last [2];

    function automatic int pick(input int d, input logic [3:0] r, input int last);
        int j;
        for (int off = 1; off <= W; off++) begin
            j = (d == 0) ? (last + off) % W : (last - off + W) % W;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] v);
        for (int i = 0; i < W; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_vld[d]  = 1'b0;
                m_cur[d]  = 0;
                m_last[d] = (d == 0) ? W - 1 : 0;
            end else if (!m_vld[d]) begin
                if (req != 4'd0) begin
                    m_cur[d] = pick(d, req, m_last[d]);
                    m_vld[d] = 1'b1;
                end
            end else if (rdy && !lck) begin
                m_last[d] = m_cur[d];
                if (req != 4'd0) begin
                    m_cur[d] = pick(d, req, m_last[d]);
                end else begin
                    m_vld[d] = 1'b0;
                end
            end
        end
    end

    function automatic logic [3:0] model_gnt(input int d);
        return m_vld[d] ? 4'(1 << m_cur[d]) : 4'd0;
    endfunction

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < NDUT; g++) begin
                logic [3:0] eg;
                logic [1:0] ei;
                eg = model_gnt(g / 3);
                ei = m_vld[g / 3] ? 2'(m_cur[g / 3]) : 2'd0;
                tests++;
                if (vld_a[g] !== m_vld[g / 3] || gnt_a[g] !== eg || idx_a[g] !== ei) begin
                    failed++;
                    $display("FAIL cycle dut%0d @%0t: got vld=%b gnt=%b idx=%0d, want vld=%b gnt=%b idx=%0d",
                             g, $time, vld_a[g], gnt_a[g], idx_a[g], m_vld[g / 3], eg, ei);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic y, input logic l);
        @(negedge clk);
        #1;
        req = r;
        rdy = y;
        lck = l;
    endtask

    // Literal expectation after the next rising edge, for DUTs and model alike.
    task automatic exp(input string nm, input logic [3:0] el, input logic [3:0] em);
        logic [3:0] e;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            e = (d == 0) ? el : em;
            tests++;
            if (model_gnt(d) !== e) begin
                failed++;
                $display("FAIL %s model dir%0d: got gnt=%b, want %b", nm, d, model_gnt(d), e);
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            e = (g / 3 == 0) ? el : em;
            tests++;
            if (gnt_a[g] !== e || vld_a[g] !== (|e) || idx_a[g] !== enc(e)) begin
                failed++;
                $display("FAIL %s dut%0d: got vld=%b gnt=%b idx=%0d, want vld=%b gnt=%b idx=%0d",
                         nm, g, vld_a[g], gnt_a[g], idx_a[g], |e, e, enc(e));
            end
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int g = 0; g < NDUT; g++) begin
            tests++;
            if (gnt_a[g] !== 4'd0 || vld_a[g] !== 1'b0 || idx_a[g] !== 2'd0) begin
                failed++;
                $display("FAIL %s dut%0d: got vld=%b gnt=%b idx=%0d, want all zero",
                         nm, g, vld_a[g], gnt_a[g], idx_a[g]);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        req   = 4'd0;
        rdy   = 1'b0;
        lck   = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        req    = 4'd0;
        rdy    = 1'b0;
        lck    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Basic grant order with wrap-around.
        drive(4'b1010, 1, 0); exp("basic0", 4'b0010, 4'b1000);
        drive(4'b1010, 1, 0); exp("basic1", 4'b1000, 4'b0010);
        drive(4'b1010, 1, 0); exp("basic2", 4'b0010, 4'b1000);
        drive(4'b0000, 1, 0); exp("basic_idle", 4'b0000, 4'b0000);

        // Fairness with all clients requesting, both directions.
        do_reset();
        drive(4'b1111, 1, 0); exp("fair0", 4'b0001, 4'b1000);
        drive(4'b1111, 1, 0); exp("fair1", 4'b0010, 4'b0100);
        drive(4'b1111, 1, 0); exp("fair2", 4'b0100, 4'b0010);
        drive(4'b1111, 1, 0); exp("fair3", 4'b1000, 4'b0001);
        drive(4'b1111, 1, 0); exp("fair4", 4'b0001, 4'b1000);
        drive(4'b0000, 1, 0); exp("fair_idle", 4'b0000, 4'b0000);

        // Backpressure: grant frozen while rdy is low even though req moves.
        drive(4'b0010, 0, 0); exp("bp_load", 4'b0010, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 0, 0); exp("bp_hold", 4'b0010, 4'b0010);
        end
        drive(4'b0100, 1, 0); exp("bp_next", 4'b0100, 4'b0100);
        drive(4'b0000, 1, 0); exp("bp_idle", 4'b0000, 4'b0000);

        // Lock holds the grant for the locked beats.
        do_reset();
        drive(4'b1111, 1, 0); exp("lck0", 4'b0001, 4'b1000);
        drive(4'b1111, 1, 0); exp("lck1", 4'b0010, 4'b0100);
        drive(4'b1111, 1, 1); exp("lck2", 4'b0010, 4'b0100);
        drive(4'b1111, 1, 1); exp("lck3", 4'b0010, 4'b0100);
        drive(4'b1111, 1, 0); exp("lck4", 4'b0100, 4'b0010);
        drive(4'b0000, 1, 0); exp("lck_idle", 4'b0000, 4'b0000);

        // Reset in the middle of an offer clears outputs before the next edge.
        drive(4'b0100, 0, 0); exp("mid_pre", 4'b0100, 4'b0100);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        req   = 4'd0;
        rdy   = 1'b0;
        #1;
        chk_zero("mid_rst");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b1111, 1, 0); exp("mid_post", 4'b0001, 4'b1000);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            req   = 4'($urandom_range(15));
            rdy   = ($urandom_range(9) < 7);
            lck   = ($urandom_range(3) == 0);
            rst_n = ($urandom_range(199) != 0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/pry2oht_rr.md
# pry2oht_rr

Round-robin arbiter built around the priority-to-one-hot selection: registers a one-hot grant among `WIDTH` requesters and offers it downstream over a valid/ready handshake. A rotating priority pointer guarantees fairness, and an optional lock holds a grant across multi-beat transfers. The block sits between a request vector from N clients and a single shared resource such as a bus, a memory port or an output queue.

## Interface
- `WIDTH`, 8: number of requesters, ≥1.
- `WIDTH_LOG`, localparam: `max(1, $clog2(WIDTH))`, width of `idx`.
- `DIRECTION`, "LSB": base scan direction. "LSB" scans upward from the pointer; "MSB" scans downward. Any other value is a `$fatal` at elaboration.
- `IMPLEMENTATION`, 0: core for the internal priority select. 0 = loop, 1 = vector, 2 = adder. Any other value is a `$fatal`.
- `clk`  in  1  clock; every register is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  WIDTH  request vector; bit i means client i requests.
- `lck`  in  1  lock, sampled only on a transfer cycle.
- `gnt`  out  WIDTH  registered one-hot grant.
- `idx`  out  WIDTH_LOG  registered binary index of `gnt`.
- `vld`  out  1  grant valid.
- `rdy`  in  1  consumer accepts the grant.

## Operation
- **State machine:** two states, IDLE and OFFER. `vld` = 1 exactly when the state is OFFER.
- **Pointer:** `ptr` is a WIDTH-bit mask of the requesters eligible first.
  - LSB: after index k is granted, the mask covers bits k+1..WIDTH-1.
  - MSB: after index k is granted, the mask covers bits 0..k-1.
- **Selection:**
  - `sel = pry2oht(req & ptr)` if that term is nonzero, otherwise `pry2oht(req)`.
  - Ties resolve per `DIRECTION`.
  - `sel` is one-hot or zero. `idx` is its binary encoding.
- **Transfer:** a transfer is any cycle with `vld & rdy`.
- **IDLE:**
  - `|req` = 1: load `gnt`/`idx` from `sel` and go to OFFER.
  - Otherwise stay in IDLE.
- **OFFER, no transfer:** `gnt` and `idx` stay frozen, whatever `req` does. A requester that drops `req` while granted is still served.
- **OFFER, transfer with `lck` = 1:**
  - `ptr` is unchanged.
  - The same `gnt`/`idx` are re-offered next cycle (stay in OFFER).
  - `req` is not consulted.
- **OFFER, transfer with `lck` = 0:**
  - `ptr` advances past `idx`.
  - `sel` is recomputed combinationally from the *advanced* pointer and the current `req`.
  - If `sel` is nonzero, load it and stay in OFFER (back-to-back grant). Otherwise go to IDLE with `gnt` = 0.
- **Wrap-around:**
  - LSB: a grant at WIDTH-1 yields an all-zero mask, so the next grant falls back to the lowest requester.
  - MSB: a grant at 0 behaves symmetrically.
- **WIDTH = 1:** `ptr` is always 0, `idx` is always 0, and `gnt` equals `vld`.

## Timing
- **Reset values (asynchronous assertion):**
  - `gnt` = 0, `idx` = 0, `vld` = 0, state = IDLE.
  - `ptr` = all ones, so the first scan starts at bit 0 (LSB) or bit WIDTH-1 (MSB).
- **Reset release:** synchronous; the first evaluation happens on the first rising edge after `rst_n` goes high.
- **Latency:** `req` sampled in IDLE at edge n gives `vld`/`gnt` valid after edge n.
- **Throughput:** one grant per cycle while `rdy` = 1 and requests remain.
- **Combinational paths:** no path from `req`/`rdy`/`lck` to any output; all outputs come straight from flops.
- **Mid-offer reset:** outputs clear immediately and any pending grant is lost.
- **Handshake rule:** while `vld` = 1 and `rdy` = 0, `gnt`/`idx` must hold stable.

## Test plan
All scenarios use WIDTH = 4.
- **LSB, basic:** reset, then `req` = 4'b1010 and `rdy` = 1 held.
  - Expected: IDLE→OFFER; `gnt` = 0010 (`idx` = 1), then 1000 (`idx` = 3), then 0010 (wrap).
- **Fairness, LSB:** `req` = 1111 and `rdy` = 1 held.
  - Expected: `gnt` = 0001, 0010, 0100, 1000, 0001, with `vld` continuously 1.
- **Backpressure:** grant 0010 offered, `rdy` = 0 for 3 cycles while `req` changes to 0100.
  - Expected: `gnt` = 0010 and `vld` = 1 throughout. After `rdy` = 1 the next grant is 0100, and the grant after that returns to IDLE when `req` = 0.
- **Lock:** `req` = 1111 and grant 0010 transferred with `lck` = 1 for two beats, then `lck` = 0.
  - Expected: `gnt` = 0010 for all three beats, then 0100.
- **MSB direction:** `req` = 1111 and `rdy` = 1.
  - Expected: `gnt` = 1000, 0100, 0010, 0001, 1000.
- **Reset mid-offer:** `rst_n` pulsed low with `vld` = 1 and `gnt` = 0100.
  - Expected: outputs become 0 before the next clock edge. After release with `req` = 1111, the first grant is 0001.
- **Every scenario above is repeated for `IMPLEMENTATION` = 0, 1 and 2** with identical expected results.
